// File: rtl/clcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clcd_pkg                                                         |
// | Purpose  : Shared state encodings, HD44780 command bytes and the power-up   |
// |            init table for the 8-bit character LCD writer.                   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package clcd_pkg;

  // Sequencer states (top level)
  typedef enum logic [2:0] {
    S_PWR  = 3'd0,   // power-on wait
    S_INIT = 3'd1,   // init-table command in flight
    S_IDLE = 3'd2,   // accepting characters
    S_DATA = 3'd3,   // character write in flight
    S_ADDR = 3'd4    // line-address command in flight
  } top_state_t;

  // Bus-cycle states (clcd_bus_cycle)
  typedef enum logic [2:0] {
    S_BUS_IDLE = 3'd0,
    S_SETUP    = 3'd1,
    S_EHI      = 3'd2,
    S_HOLD     = 3'd3,
    S_EXEC     = 3'd4
  } bus_state_t;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] CMD_LINE1     = 8'h80;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;

  localparam int INIT_LEN = 6;

  // Power-up command sequence: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_cmd = CMD_FUNC_8B2L;
      3'd3:             init_cmd = CMD_DISP_ON;
      3'd4:             init_cmd = CMD_CLEAR;
      default:          init_cmd = CMD_ENTRY_INC;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/clcd_bus_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clcd_bus_cycle                                                   |
// | Purpose  : One HD44780 write transaction: setup, E pulse, hold, then the    |
// |            controller execution wait. Pulses o_done in the last exec cycle. |
// | Ports    : i_clk, i_reset_n (async active-low)                              |
// |            i_start, i_rs, i_db[7:0], i_long_wait  - transaction request     |
// |            o_done                                 - end-of-exec pulse       |
// |            o_lcd_rs, o_lcd_e, o_lcd_db[7:0]       - LCD bus                 |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module clcd_bus_cycle
  import clcd_pkg::*;
#(
  parameter int P_CNT_1US   = 125,
  parameter int P_SETUP_CYC = 10,
  parameter int P_E_CYC     = 40,
  parameter int P_CMD_US    = 50,
  parameter int P_CLR_US    = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_db,
  input  logic       i_long_wait,
  output logic       o_done,
  output logic       o_lcd_rs,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db
);

  localparam logic [31:0] c_us_last    = 32'(P_CNT_1US - 1);
  localparam logic [31:0] c_setup_last = 32'(P_SETUP_CYC - 1);
  localparam logic [31:0] c_e_last     = 32'(P_E_CYC - 1);
  localparam logic [31:0] c_cmd_last   = 32'(P_CMD_US - 1);
  localparam logic [31:0] c_clr_last   = 32'(P_CLR_US - 1);

  bus_state_t  r_state, w_next;
  logic [31:0] r_cyc, r_us_pre, r_us;
  logic        r_rs, r_e, r_long;
  logic [7:0]  r_db;
  logic        w_clr, w_done, w_load, w_us_tick;
  logic [31:0] w_wait_last;

  assign w_us_tick   = (r_us_pre == c_us_last);
  assign w_wait_last = r_long ? c_clr_last : c_cmd_last;
  // A new request is taken from idle, or back-to-back at the end of exec.
  assign w_load      = i_start && ((r_state == S_BUS_IDLE) || w_done);

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_BUS_IDLE: if (i_start) begin w_next = S_SETUP; w_clr = 1'b1; end
      S_SETUP:    if (r_cyc == c_setup_last) begin w_next = S_EHI;  w_clr = 1'b1; end
      S_EHI:      if (r_cyc == c_e_last)     begin w_next = S_HOLD; w_clr = 1'b1; end
      S_HOLD:     if (r_cyc == c_setup_last) begin w_next = S_EXEC; w_clr = 1'b1; end
      S_EXEC: begin
        if (w_us_tick && (r_us == w_wait_last)) begin
          w_done = 1'b1;
          w_clr  = 1'b1;
          w_next = i_start ? S_SETUP : S_BUS_IDLE;
        end
      end
      default: begin w_next = S_BUS_IDLE; w_clr = 1'b1; end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_BUS_IDLE;
      r_cyc    <= '0;
      r_us_pre <= '0;
      r_us     <= '0;
      r_rs     <= 1'b0;
      r_db     <= '0;
      r_long   <= 1'b0;
      r_e      <= 1'b0;
    end else begin
      r_state <= w_next;
      // E is registered from the next state so the pin never glitches.
      r_e     <= (w_next == S_EHI);
      if (w_clr || (r_state == S_BUS_IDLE)) begin
        r_cyc    <= '0;
        r_us_pre <= '0;
        r_us     <= '0;
      end else begin
        r_cyc    <= r_cyc + 32'd1;
        r_us_pre <= w_us_tick ? 32'd0 : r_us_pre + 32'd1;
        if (w_us_tick) r_us <= r_us + 32'd1;
      end
      if (w_load) begin
        r_rs   <= i_rs;
        r_db   <= i_db;
        r_long <= i_long_wait;
      end
    end
  end

  assign o_done   = w_done;
  assign o_lcd_rs = r_rs;
  assign o_lcd_e  = r_e;
  assign o_lcd_db = r_db;

endmodule
`default_nettype wire

// File: rtl/clcd_8bit_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clcd_8bit_writer                                                 |
// | Purpose  : HD44780 8-bit write-only LCD driver. Runs the power-up init      |
// |            table, then writes one character per nonzero i_data strobe.     |
// | Ports    : i_clk, i_reset_n (async active-low), i_data[7:0] (0 = no req)    |
// |            o_busy, o_lcd_rs, o_lcd_rw (tied 0), o_lcd_e, o_lcd_db[7:0]      |
// | Config   : CLCD_LINE_WRAP_EN - track the column and emit 0xC0 / 0x80 line   |
// |            address commands after columns 15 / 31.                          |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module clcd_8bit_writer
  import clcd_pkg::*;
#(
  parameter int P_CNT_1US   = 125,
  parameter int P_INIT_US   = 20000,
  parameter int P_SETUP_CYC = 10,
  parameter int P_E_CYC     = 40,
  parameter int P_CMD_US    = 50,
  parameter int P_CLR_US    = 2000
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db
);

  localparam logic [31:0] c_us_last   = 32'(P_CNT_1US - 1);
  localparam logic [31:0] c_init_last = 32'(P_INIT_US - 1);
  localparam logic [2:0]  c_idx_last  = 3'(INIT_LEN - 1);

  top_state_t  r_state, w_next;
  logic [31:0] r_us_pre, r_us;
  logic [2:0]  r_idx;
  logic        r_busy;
  logic        w_start, w_rs, w_long, w_idx_inc, w_bus_done, w_pwr_done;
  logic [7:0]  w_db, w_init_cmd, w_next_init_cmd;
`ifdef CLCD_LINE_WRAP_EN
  logic [4:0]  r_col;
  logic        w_col_inc, w_col_clr;
`endif

  assign w_pwr_done      = (r_state == S_PWR) && (r_us_pre == c_us_last) && (r_us == c_init_last);
  assign w_init_cmd      = init_cmd(r_idx);
  assign w_next_init_cmd = init_cmd(r_idx + 3'd1);

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_rs      = 1'b0;
    w_db      = 8'h00;
    w_long    = 1'b0;
    w_idx_inc = 1'b0;
`ifdef CLCD_LINE_WRAP_EN
    w_col_inc = 1'b0;
    w_col_clr = 1'b0;
`endif
    case (r_state)
      S_PWR: begin
        if (w_pwr_done) begin
          w_next  = S_INIT;
          w_start = 1'b1;
          w_db    = w_init_cmd;
          w_long  = (w_init_cmd == CMD_CLEAR);
        end
      end
      S_INIT: begin
        if (w_bus_done) begin
`ifdef CLCD_LINE_WRAP_EN
          if (w_init_cmd == CMD_CLEAR) w_col_clr = 1'b1;
`endif
          if (r_idx == c_idx_last) begin
            w_next = S_IDLE;
          end else begin
            w_idx_inc = 1'b1;
            w_start   = 1'b1;
            w_db      = w_next_init_cmd;
            w_long    = (w_next_init_cmd == CMD_CLEAR);
          end
        end
      end
      S_IDLE: begin
        if (i_data != 8'h00) begin
          w_next  = S_DATA;
          w_start = 1'b1;
          w_rs    = 1'b1;
          w_db    = i_data;
        end
      end
      S_DATA: begin
        if (w_bus_done) begin
          w_next = S_IDLE;
`ifdef CLCD_LINE_WRAP_EN
          // r_col is the column just written; 31 + 1 wraps to 0 in 5 bits.
          w_col_inc = 1'b1;
          if (r_col == 5'd15) begin
            w_next  = S_ADDR;
            w_start = 1'b1;
            w_db    = CMD_LINE2;
          end else if (r_col == 5'd31) begin
            w_next  = S_ADDR;
            w_start = 1'b1;
            w_db    = CMD_LINE1;
          end
`endif
        end
      end
      S_ADDR: if (w_bus_done) w_next = S_IDLE;
      default: w_next = S_PWR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= S_PWR;
      r_us_pre <= '0;
      r_us     <= '0;
      r_idx    <= '0;
      r_busy   <= 1'b1;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      if (r_state == S_PWR) begin
        if (r_us_pre == c_us_last) begin
          r_us_pre <= '0;
          r_us     <= r_us + 32'd1;
        end else begin
          r_us_pre <= r_us_pre + 32'd1;
        end
      end
      if (w_idx_inc) r_idx <= r_idx + 3'd1;
    end
  end

`ifdef CLCD_LINE_WRAP_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)     r_col <= '0;
    else if (w_col_clr) r_col <= '0;
    else if (w_col_inc) r_col <= r_col + 5'd1;
  end
`endif

  clcd_bus_cycle #(
    .P_CNT_1US   (P_CNT_1US),
    .P_SETUP_CYC (P_SETUP_CYC),
    .P_E_CYC     (P_E_CYC),
    .P_CMD_US    (P_CMD_US),
    .P_CLR_US    (P_CLR_US)
  ) u_bus (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_start     (w_start),
    .i_rs        (w_rs),
    .i_db        (w_db),
    .i_long_wait (w_long),
    .o_done      (w_bus_done),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_e     (o_lcd_e),
    .o_lcd_db    (o_lcd_db)
  );

  assign o_busy   = r_busy;
  assign o_lcd_rw = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_clcd_8bit_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clcd_8bit_writer                                              |
// | Purpose  : Scoreboard bench for clcd_8bit_writer. Stimulus pushes expected  |
// |            {RS,DB} per E pulse; a monitor pops and compares on each E rise. |
// | Config   : CLCD_LINE_WRAP_EN selects the line-wrap expectations.           |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_clcd_8bit_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data;
  logic       busy, rs, rw, e;
  logic [7:0] db;

  always #5 clk = ~clk;

  clcd_8bit_writer #(
    .P_CNT_1US(2), .P_INIT_US(10), .P_SETUP_CYC(10),
    .P_E_CYC(40), .P_CMD_US(5), .P_CLR_US(20)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_data(i_data), .o_busy(busy),
    .o_lcd_rs(rs), .o_lcd_rw(rw), .o_lcd_e(e), .o_lcd_db(db)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         req_cyc = 0;
  int         n_pulses = 0;
  bit         lat_en = 1'b0;
  bit         watch42 = 1'b0;
  bit         seen42 = 1'b0;
  logic [8:0] exp_q[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one scoreboard pop per E pulse, plus pulse-shape checks.
  logic       prev_e = 1'b0;
  int         width = 0;
  int         fall_cyc = 0;
  bit         last_clear = 1'b0;
  logic [8:0] cur = '0;

  always @(negedge clk) begin
    if (watch42 && db == 8'h42) seen42 = 1'b1;
    if (e && !prev_e) begin
      n_pulses++;
      width = 0;
      cur = {rs, db};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_e_pulse: got rs/db %0h, expected no pulse", cur);
      end else begin
        check("e_pulse_rs_db", {23'd0, cur}, {23'd0, exp_q.pop_front()});
      end
      if (lat_en) begin
        check("e_rise_latency", cyc - req_cyc, 11);
        lat_en = 1'b0;
      end
      if (last_clear) begin
        check("gap_after_clear_ge40", {31'd0, (cyc - fall_cyc) >= 40}, 1);
        last_clear = 1'b0;
      end
    end
    if (e) width++;
    if (!e && prev_e) begin
      if (rst_n) check("e_width", width, 40);
      fall_cyc = cyc;
      last_clear = (cur == 9'h001);
    end
    prev_e = e;
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy !== 1'b0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: busy still %0b, expected 0", name, busy);
    end
  endtask

  task automatic send_char(input logic [7:0] ch);
    @(negedge clk);
    i_data = ch;
    @(negedge clk);
    i_data = 8'h00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int k;
    logic [7:0] ch;
    int exp_p;

    rst_n  = 1'b0;
    i_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 1);
    check("reset_e",    {31'd0, e}, 0);
    check("reset_rs",   {31'd0, rs}, 0);
    check("reset_db",   {24'd0, db}, 0);
    check("reset_rw",   {31'd0, rw}, 0);

    push_init();
    rst_n = 1'b1;
    @(negedge clk);
    wait_idle("init");
    check("init_queue_drained", exp_q.size(), 0);
    check("busy_after_init", {31'd0, busy}, 0);

    // Single character from idle, with latency check.
    p0 = n_pulses;
    @(negedge clk);
    check("busy_before_req", {31'd0, busy}, 0);
    i_data  = 8'h41;
    req_cyc = cyc;
    lat_en  = 1'b1;
    exp_q.push_back({1'b1, 8'h41});
    @(negedge clk);
    i_data = 8'h00;
    check("busy_after_req", {31'd0, busy}, 1);

    // Request while busy must be dropped.
    repeat (20) @(negedge clk);
    watch42 = 1'b1;
    i_data  = 8'h42;
    @(negedge clk);
    i_data = 8'h00;
    wait_idle("char41");
    repeat (5) @(negedge clk);
    check("db_never_42", {31'd0, seen42}, 0);
    watch42 = 1'b0;
    check("pulses_41_42", n_pulses - p0, 1);
    check("queue_after_41", exp_q.size(), 0);

    // Reset while E is high: E drops at once and init reruns.
    exp_q.push_back({1'b1, 8'h43});
    send_char(8'h43);
    k = 0;
    while (e !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("e_high_before_reset", {31'd0, e}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("e_drop_on_reset", {31'd0, e}, 0);
    check("busy_on_reset", {31'd0, busy}, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    @(negedge clk);
    wait_idle("reinit");
    check("reinit_queue_drained", exp_q.size(), 0);

    // 32 characters '0'.. with optional line-wrap commands.
    for (int i = 0; i < 32; i++) begin
      ch = 8'h30 + 8'(i);
      exp_q.push_back({1'b1, ch});
      exp_p = 1;
`ifdef CLCD_LINE_WRAP_EN
      if (i == 15) begin exp_q.push_back({1'b0, 8'hC0}); exp_p = 2; end
      if (i == 31) begin exp_q.push_back({1'b0, 8'h80}); exp_p = 2; end
`endif
      p0 = n_pulses;
      send_char(ch);
      wait_idle("char_stream");
      check("pulses_per_char", n_pulses - p0, exp_p);
    end
    check("final_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
